// File: rtl/hex_scan_scheduler.sv
// Time-multiplexes one hex_decoder across NUM_DIGITS seven-segment digit registers.
// Optional HEX_BLINK_EN adds a per-digit blink mask applied after the digit registers.

module hex_decoder (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // active-low, segment g is the MSB
  always_comb begin
    seg = 7'b111_1111;
    unique case (nib)
      4'h0: seg = 7'b100_0000;
      4'h1: seg = 7'b111_1001;
      4'h2: seg = 7'b010_0100;
      4'h3: seg = 7'b011_0000;
      4'h4: seg = 7'b001_1001;
      4'h5: seg = 7'b001_0010;
      4'h6: seg = 7'b000_0010;
      4'h7: seg = 7'b111_1000;
      4'h8: seg = 7'b000_0000;
      4'h9: seg = 7'b001_0000;
      4'hA: seg = 7'b000_1000;
      4'hB: seg = 7'b000_0011;
      4'hC: seg = 7'b100_0110;
      4'hD: seg = 7'b010_0001;
      4'hE: seg = 7'b000_0110;
      4'hF: seg = 7'b000_1110;
    endcase
  end
endmodule

module hex_digit_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [6:0] d,
  output logic [6:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= 7'b111_1111;
    else if (we) q <= d;
  end
endmodule

module hex_scan_scheduler #(
  parameter int NUM_DIGITS = 6,
  parameter int UPDATE_DIV = 4,
  parameter int BLINK_HALF = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef HEX_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic                    busy,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] hex_flat
);
  localparam int CW = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || UPDATE_DIV < 1 || BLINK_HALF < 1) begin : g_bad_param
    $error("hex_scan_scheduler: illegal parameter value");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q;
  logic [IW-1:0]                 idx_q;
  logic [NUM_DIGITS-1:0][3:0]    shadow_val;
  logic [NUM_DIGITS-1:0]         shadow_blank;
  logic [NUM_DIGITS-1:0][6:0]    digit_q;
  logic [NUM_DIGITS-1:0]         digit_we;
  logic [6:0]                    dec_seg, wr_seg;
  logic                          accept, slot_end, last_slot;

  assign accept    = (state_q == IDLE) && load_valid;
  assign slot_end  = (state_q == SCAN) && (cnt_q == CW'(UPDATE_DIV - 1));
  assign last_slot = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_d = SCAN;
      end
      SCAN: begin
        busy = 1'b1;
        if (last_slot) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val   <= '0;
      shadow_blank <= '0;
      done         <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= last_slot;
      if (accept) begin
        shadow_val   <= load_value;
        shadow_blank <= blank_mask;
        cnt_q        <= '0;
        idx_q        <= '0;
      end else if (slot_end) begin
        cnt_q <= '0;
        idx_q <= idx_q + 1'b1;
      end else if (state_q == SCAN) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  hex_decoder u_dec (.nib(shadow_val[idx_q]), .seg(dec_seg));

  assign wr_seg = shadow_blank[idx_q] ? 7'b111_1111 : dec_seg;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign digit_we[k] = slot_end && (idx_q == IW'(k));
    hex_digit_reg u_reg (
      .clk(clk), .rst_n(rst_n), .we(digit_we[k]), .d(wr_seg), .q(digit_q[k])
    );
  end

`ifdef HEX_BLINK_EN
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  logic [BW-1:0]         blink_cnt;
  logic                  phase;
  logic [NUM_DIGITS-1:0] shadow_blink;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt    <= '0;
      phase        <= 1'b0;
      shadow_blink <= '0;
    end else begin
      if (accept) shadow_blink <= blink_mask;
      if (blink_cnt == BW'(BLINK_HALF - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_blink
    assign hex_flat[7*k +: 7] = (phase && shadow_blink[k]) ? 7'b111_1111 : digit_q[k];
  end
`else
  assign hex_flat = digit_q;
`endif
endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Directed bench for hex_scan_scheduler (NUM_DIGITS=6, UPDATE_DIV=4).
module tb_hex_scan_scheduler;
  localparam int ND = 6;
  localparam int UD = 4;
  localparam int BH = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [4*ND-1:0] load_value = '0;
  logic [ND-1:0]   blank_mask = '0;
`ifdef HEX_BLINK_EN
  logic [ND-1:0]   blink_mask = '0;
`endif
  logic            busy, done;
  logic [7*ND-1:0] hex_flat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hex_scan_scheduler #(.NUM_DIGITS(ND), .UPDATE_DIV(UD), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .blank_mask(blank_mask),
`ifdef HEX_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .busy(busy), .done(done), .hex_flat(hex_flat)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] dig(input int k);
    return hex_flat[7*k +: 7];
  endfunction

  localparam logic [41:0] ALL_OFF = {ND{7'b111_1111}};
  localparam logic [41:0] ALL_ONE = {ND{7'b111_1001}};
  localparam logic [41:0] ALL_TWO = {ND{7'b010_0100}};

  initial begin
    // reset state
    #12;
    chk("rst_hex", hex_flat, ALL_OFF);
    chk("rst_ready", load_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_done", done, 0);
    end
    chk("idle_hex", hex_flat, ALL_OFF);

    // load 012345: digit k shows nibble k
    load_value = 24'h012345; blank_mask = '0; load_valid = 1'b1;
    tick();                                  // E0
    load_valid = 1'b0;
    chk("scan_busy", busy, 1);
    chk("scan_ready", load_ready, 0);
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 3)  chk("d0_pre", dig(0), 7'b111_1111);
      if (k == 4)  chk("d0_5", dig(0), 7'b001_0010);
      if (k == 23) chk("done_early", done, 0);
      if (k == 24) begin
        chk("d5_0", dig(5), 7'b100_0000);
        chk("done_pulse", done, 1);
        chk("done_ready", load_ready, 1);
        chk("done_busy", busy, 0);
        chk("word_012345", hex_flat,
            {7'b100_0000, 7'b111_1001, 7'b010_0100, 7'b011_0000, 7'b001_1001, 7'b001_0010});
      end
      if (k == 25) chk("done_drop", done, 0);
    end

    // blanking
    load_value = 24'hFF00A8; blank_mask = 6'b110000; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 1; k <= 24; k++) tick();
    chk("blank_word", hex_flat,
        {7'b111_1111, 7'b111_1111, 7'b100_0000, 7'b100_0000, 7'b000_1000, 7'b000_0000});

    // back-to-back with load_valid held; value changes during scan must not leak
    tick();
    load_value = 24'h111111; blank_mask = '0; load_valid = 1'b1;
    tick();                                  // E0 accept
    load_value = 24'h222222;
    for (int k = 1; k <= 24; k++) tick();
    chk("b2b_first", hex_flat, ALL_ONE);
    chk("b2b_done", done, 1);
    chk("b2b_ready", load_ready, 1);
    tick();                                  // second accept on the done cycle edge
    chk("b2b_accept", busy, 1);
    load_valid = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 5) begin load_value = 24'h333333; load_valid = 1'b1; end
      if (k == 6) load_valid = 1'b0;
      tick();
      if (k == 4) chk("b2b_d0", dig(0), 7'b010_0100);
    end
    chk("b2b_second", hex_flat, ALL_TWO);
    chk("b2b_done2", done, 1);
    tick();
    chk("pulse_ignored", busy, 0);

    // reset mid-scan
    load_value = 24'h012345; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hex", hex_flat, ALL_OFF);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", load_ready, 1);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) chk("post_rst_done", done, 0);
    end
    chk("post_rst_ready", load_ready, 1);
    chk("post_rst_hex", hex_flat, ALL_OFF);

`ifdef HEX_BLINK_EN
    begin
      int off_cnt;
      load_value = 24'h000009; blank_mask = '0; blink_mask = 6'b000001; load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int k = 1; k <= 24; k++) tick();
      off_cnt = 0;
      for (int k = 0; k < 32; k++) begin
        tick();
        if (dig(0) == 7'b111_1111) off_cnt++;
        else chk("blink_on", dig(0), 7'b001_0000);
        chk("blink_steady", hex_flat[7*ND-1:7], {5{7'b100_0000}});
      end
      chk("blink_half", off_cnt, 16);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hex_scan_scheduler.md
Name: hex_scan_scheduler

Overview:
- Shares one hex_decoder instance across NUM_DIGITS seven-segment digits. Digits are the score/timer display of the footies game.
- Accepts a packed nibble word through a valid/ready handshake, then steps the shared decoder across the digits, one digit per UPDATE_DIV cycles.
- Latches each decoded pattern into a per-digit output register that drives the board HEX pins.
- Sits between game-state logic (score/timer) and the HEX pins.

Parameters:
- NUM_DIGITS, 6, number of digits driven; legal range 1..8.
- UPDATE_DIV, 4, clock cycles spent per digit slot; must be >= 1.
- BLINK_HALF, 25000000, clock cycles per blink half-period; used only with HEX_BLINK_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- load_valid  input  1  requester has a new display word.
- load_ready  output  1  block can accept a word.
- load_value  input  4*NUM_DIGITS  nibble k = bits [4k+3:4k], shown on digit k.
- blank_mask  input  NUM_DIGITS  bit k = 1 forces digit k all-off.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when the last digit has been written.
- hex_flat  output  7*NUM_DIGITS  digit k pattern = bits [7k+6:7k], active-low segments.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all hex_flat bits = 1 (all segments off).
  - load_ready=1, busy=0, done=0.
  - Shadow registers, digit index and slot counter cleared to 0.
- States: IDLE, SCAN.
- IDLE:
  - load_ready=1, busy=0.
  - On a clock edge with load_valid=1, capture load_value and blank_mask into shadow registers, set idx=0, cnt=0, state=SCAN.
  - From the next cycle: load_ready=0, busy=1.
- SCAN:
  - Shared decoder input = shadow nibble[idx], driven combinationally.
  - cnt counts 0..UPDATE_DIV-1. On the edge where cnt=UPDATE_DIV-1:
    - digit register idx <= 7'b111_1111 if shadow blank bit idx = 1, else the decoder output.
    - cnt <= 0, idx <= idx+1.
  - On the final slot edge (idx=NUM_DIGITS-1):
    - state <= IDLE, done <= 1 for exactly one cycle.
    - load_ready <= 1 and busy <= 0 in that same cycle.
  - load_valid is ignored while in SCAN; the requester holds it until load_ready=1.
- Timing: with acceptance at edge E0, digit k updates at edge E0+(k+1)*UPDATE_DIV. Total busy time = NUM_DIGITS*UPDATE_DIV cycles. Earliest next acceptance is the edge after done is high.
- Digits not yet rewritten keep their previous pattern; there is no flicker or blanking between loads.
- Encoding (active-low, segment g = MSB): decoder patterns for 0..F. Examples: 0=7'b100_0000, 1=7'b111_1001, 8=7'b000_0000, A=7'b000_1000, F=7'b000_1110.
- UPDATE_DIV=1: one digit per cycle, and cnt is effectively absent.
- Reset mid-scan: the scan aborts immediately and all digits go blank. A word accepted just before reset is discarded.
- load_valid held continuously: back-to-back scans with exactly one IDLE cycle between them (the done cycle).

Optional Feature:
- Macro: HEX_BLINK_EN.
- Defined:
  - Adds input blink_mask [NUM_DIGITS-1:0], captured together with blank_mask on acceptance.
  - A free-running counter toggles a phase bit every BLINK_HALF cycles; phase resets to 0.
  - While phase=1, every digit whose captured blink bit = 1 drives 7'b111_1111 on hex_flat. This is a combinational mask after the digit registers.
  - While phase=0, digits show their stored pattern.
  - blink_mask has no effect on scheduling, done or busy.
- Undefined: no blink_mask port, no counter, and hex_flat connects directly to the digit registers.

Test Plan:
- Reset release, no load -> hex_flat all ones, load_ready=1, busy=0, done never pulses.
- UPDATE_DIV=4, load 24'h012345 at E0 with blank_mask=0:
  - digit0 reads 7'b001_0010 ('5') at E0+4; digit5 reads 7'b100_0000 at E0+24.
  - done high exactly in the cycle after E0+24.
- blank_mask=6'b110000, load_value=24'hFF00A8 -> digits 4,5 = 7'b111_1111; digit1=7'b000_1000 ('A'), digit0=7'b000_0000.
- load_valid held high over two words (24'h111111, then 24'h222222) -> second accepted on the done cycle; no gap beyond one IDLE cycle; load_valid pulses during SCAN are ignored.
- rst_n asserted at E0+10 of a scan -> all outputs blank immediately (asynchronously); after release, state IDLE and load_ready=1.
- HEX_BLINK_EN, BLINK_HALF=8, blink_mask=6'b000001, load_value=24'h000009:
  - digit0 alternates 7'b001_0000 and 7'b111_1111 every 8 cycles; other digits stay steady.
